// File: rtl/salu_waitcnt_ctrl_if.sv
// rtl/salu_waitcnt_ctrl_if.sv - issue/return/waitcnt handshake bundle for salu_waitcnt_ctrl
interface salu_waitcnt_ctrl_if #(
    parameter int NUM_WAVES = 8,
    parameter int CNT_W     = 6
);
    localparam int WAVE_W = $clog2(NUM_WAVES);

    logic                 issue_valid;
    logic [WAVE_W-1:0]    issue_wave;
    logic [1:0]           issue_type;
    logic                 issue_ready;
    logic                 ret_valid;
    logic [WAVE_W-1:0]    ret_wave;
    logic [1:0]           ret_type;
    logic                 wait_valid;
    logic [WAVE_W-1:0]    wait_wave;
    logic [1:0]           wait_type;
    logic [CNT_W-1:0]     wait_thresh;
    logic                 wait_ready;
    logic [NUM_WAVES-1:0] wave_stall;
    logic                 done_valid;
    logic [WAVE_W-1:0]    done_wave;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output issue_valid, issue_wave, issue_type,
        output ret_valid, ret_wave, ret_type,
        output wait_valid, wait_wave, wait_type, wait_thresh,
        input  issue_ready, wait_ready, wave_stall, done_valid, done_wave,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wave, issue_type,
        input  ret_valid, ret_wave, ret_type,
        input  wait_valid, wait_wave, wait_type, wait_thresh,
        output issue_ready, wait_ready, wave_stall, done_valid, done_wave,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/salu_waitcnt_ctrl.sv
// rtl/salu_waitcnt_ctrl.sv - per-wave outstanding counters and s_waitcnt sequencer (option: SALU_WAITCNT_ERR_EN)
module salu_waitcnt_ctrl #(
    parameter int NUM_WAVES = 8,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    salu_waitcnt_ctrl_if.slave   bus
);
    localparam int WAVE_W = $clog2(NUM_WAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

    state_e            state_q  [NUM_WAVES];
    state_e            state_d  [NUM_WAVES];
    logic [1:0]        type_q   [NUM_WAVES];
    logic [1:0]        type_d   [NUM_WAVES];
    logic [CNT_W-1:0]  thresh_q [NUM_WAVES];
    logic [CNT_W-1:0]  thresh_d [NUM_WAVES];
    logic [CNT_W-1:0]  cnt_q    [NUM_WAVES][4];
    logic [CNT_W-1:0]  cnt_d    [NUM_WAVES][4];
    logic [WAVE_W-1:0] ptr_q, ptr_d;

    logic              issue_ready_w;
    logic              issue_acc;
    logic              grant_valid;
    logic [WAVE_W-1:0] grant_idx;
    int unsigned       arb_idx;

    assign issue_ready_w   = cnt_q[bus.issue_wave][bus.issue_type] != CNT_MAX;
    assign issue_acc       = bus.issue_valid && issue_ready_w;
    assign bus.issue_ready = issue_ready_w;
    assign bus.wait_ready  = state_q[bus.wait_wave] == ST_IDLE;
    assign bus.done_valid  = grant_valid;
    assign bus.done_wave   = grant_valid ? grant_idx : '0;

    always_comb begin
        for (int w = 0; w < NUM_WAVES; w++) begin
            bus.wave_stall[w] = state_q[w] != ST_IDLE;
        end
    end

    // Simultaneous issue and return on one counter cancel out; returns at zero are dropped.
    always_comb begin
        for (int w = 0; w < NUM_WAVES; w++) begin
            for (int t = 0; t < 4; t++) begin
                cnt_d[w][t] = cnt_q[w][t];
                if (issue_acc && bus.issue_wave == WAVE_W'(w) && bus.issue_type == 2'(t))
                    cnt_d[w][t] = cnt_d[w][t] + CNT_W'(1);
                if (bus.ret_valid && bus.ret_wave == WAVE_W'(w) && bus.ret_type == 2'(t)
                    && cnt_q[w][t] != '0)
                    cnt_d[w][t] = cnt_d[w][t] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int i = 0; i < NUM_WAVES; i++) begin
            arb_idx = (int'(ptr_q) + i) % NUM_WAVES;
            if (!grant_valid && state_q[arb_idx] == ST_DONE) begin
                grant_valid = 1'b1;
                grant_idx   = WAVE_W'(arb_idx);
            end
        end
        ptr_d = grant_valid ? WAVE_W'((int'(grant_idx) + 1) % NUM_WAVES) : ptr_q;

        for (int w = 0; w < NUM_WAVES; w++) begin
            state_d[w]  = state_q[w];
            type_d[w]   = type_q[w];
            thresh_d[w] = thresh_q[w];
            case (state_q[w])
                ST_IDLE: if (bus.wait_valid && bus.wait_wave == WAVE_W'(w)) begin
                    state_d[w]  = ST_WAIT;
                    type_d[w]   = bus.wait_type;
                    thresh_d[w] = bus.wait_thresh;
                end
                ST_WAIT: if (cnt_q[w][type_q[w]] <= thresh_q[w]) state_d[w] = ST_DONE;
                ST_DONE: if (grant_valid && grant_idx == WAVE_W'(w)) state_d[w] = ST_IDLE;
                default: state_d[w] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int w = 0; w < NUM_WAVES; w++) begin
                state_q[w]  <= ST_IDLE;
                type_q[w]   <= '0;
                thresh_q[w] <= '0;
                for (int t = 0; t < 4; t++) cnt_q[w][t] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int w = 0; w < NUM_WAVES; w++) begin
                state_q[w]  <= state_d[w];
                type_q[w]   <= type_d[w];
                thresh_q[w] <= thresh_d[w];
                for (int t = 0; t < 4; t++) cnt_q[w][t] <= cnt_d[w][t];
            end
        end
    end

`ifdef SALU_WAITCNT_ERR_EN
    logic err_ovf_q, err_unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | (bus.issue_valid && !issue_ready_w);
            err_unf_q <= err_unf_q | (bus.ret_valid && cnt_q[bus.ret_wave][bus.ret_type] == '0);
        end
    end

    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_salu_waitcnt_ctrl.sv
// tb/tb_salu_waitcnt_ctrl.sv - directed self-checking bench for salu_waitcnt_ctrl
module tb_salu_waitcnt_ctrl;
    localparam int NUM_WAVES = 8;
    localparam int CNT_W     = 6;
`ifdef SALU_WAITCNT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    salu_waitcnt_ctrl_if #(.NUM_WAVES(NUM_WAVES), .CNT_W(CNT_W)) bus ();

    salu_waitcnt_ctrl #(.NUM_WAVES(NUM_WAVES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_op(input int w, input int t);
        bus.issue_valid = 1'b1;
        bus.issue_wave  = 3'(w);
        bus.issue_type  = 2'(t);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        #1;
    endtask

    task automatic ret_op(input int w, input int t);
        bus.ret_valid = 1'b1;
        bus.ret_wave  = 3'(w);
        bus.ret_type  = 2'(t);
        @(posedge clk); #1;
        bus.ret_valid = 1'b0;
        #1;
    endtask

    task automatic wait_req(input int w, input int t, input int th);
        bus.wait_valid  = 1'b1;
        bus.wait_wave   = 3'(w);
        bus.wait_type   = 2'(t);
        bus.wait_thresh = 6'(th);
        @(posedge clk); #1;
        bus.wait_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.issue_valid = 0; bus.issue_wave = 0; bus.issue_type = 0;
        bus.ret_valid   = 0; bus.ret_wave   = 0; bus.ret_type   = 0;
        bus.wait_valid  = 0; bus.wait_wave  = 0; bus.wait_type  = 0; bus.wait_thresh = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_issue_ready", 32'(bus.issue_ready), 1);
        check("rst_wait_ready", 32'(bus.wait_ready), 1);
        check("rst_stall", 32'(bus.wave_stall), 0);
        check("rst_done_valid", 32'(bus.done_valid), 0);
        check("rst_done_wave", 32'(bus.done_wave), 0);
        check("rst_err_ovf", 32'(bus.err_overflow), 0);
        check("rst_err_unf", 32'(bus.err_underflow), 0);

        // wave 0: vm count 3, wait until <= 1
        repeat (3) issue_op(0, 1);
        wait_req(0, 1, 1);
        check("t1_stall_set", 32'(bus.wave_stall[0]), 1);
        check("t1_wait_ready_busy", 32'(bus.wait_ready), 0);
        ret_op(0, 1);
        check("t1_no_done_cnt2", 32'(bus.done_valid), 0);
        ret_op(0, 1);
        check("t1_no_done_edge_k", 32'(bus.done_valid), 0);
        cyc();
        check("t1_done_valid", 32'(bus.done_valid), 1);
        check("t1_done_wave", 32'(bus.done_wave), 0);
        check("t1_stall_during_done", 32'(bus.wave_stall[0]), 1);
        cyc();
        check("t1_stall_clear", 32'(bus.wave_stall[0]), 0);
        check("t1_done_drop", 32'(bus.done_valid), 0);

        // waves 1,3 DONE together then 5 behind them: RR order 1,3,5
        issue_op(1, 1);
        wait_req(1, 1, 0);
        bus.wait_valid = 1; bus.wait_wave = 3; bus.wait_type = 0; bus.wait_thresh = 0;
        bus.ret_valid  = 1; bus.ret_wave  = 1; bus.ret_type  = 1;
        @(posedge clk); #1;
        bus.ret_valid = 0;
        bus.wait_wave = 5;
        @(posedge clk); #1;
        bus.wait_valid = 0;
        #1;
        check("rr_first_valid", 32'(bus.done_valid), 1);
        check("rr_first_wave", 32'(bus.done_wave), 1);
        cyc();
        check("rr_second_wave", 32'(bus.done_wave), 3);
        cyc();
        check("rr_third_valid", 32'(bus.done_valid), 1);
        check("rr_third_wave", 32'(bus.done_wave), 5);
        cyc();
        check("rr_idle_after", 32'(bus.done_valid), 0);
        check("rr_stall_clear", 32'(bus.wave_stall), 0);

        // wave 2 lgk at zero: no bypass, done exactly two edges after accept
        wait_req(2, 3, 0);
        check("t2_stall", 32'(bus.wave_stall[2]), 1);
        check("t2_no_done_c1", 32'(bus.done_valid), 0);
        cyc();
        check("t2_done_valid", 32'(bus.done_valid), 1);
        check("t2_done_wave", 32'(bus.done_wave), 2);
        cyc();
        check("t2_stall_clear", 32'(bus.wave_stall[2]), 0);

        // pointer now 3: waves 1 and 5 together -> 5 first, 1 after wrap
        issue_op(5, 1);
        wait_req(5, 1, 0);
        bus.wait_valid = 1; bus.wait_wave = 1; bus.wait_type = 0; bus.wait_thresh = 0;
        bus.ret_valid  = 1; bus.ret_wave  = 5; bus.ret_type  = 1;
        @(posedge clk); #1;
        bus.wait_valid = 0; bus.ret_valid = 0;
        #1;
        check("wrap_no_done_yet", 32'(bus.done_valid), 0);
        cyc();
        check("wrap_first_wave", 32'(bus.done_wave), 5);
        cyc();
        check("wrap_second_valid", 32'(bus.done_valid), 1);
        check("wrap_second_wave", 32'(bus.done_wave), 1);
        cyc();
        check("wrap_idle", 32'(bus.done_valid), 0);

        // wave 4 exp: simultaneous issue+return at 2, then fill to 63
        repeat (2) issue_op(4, 2);
        bus.issue_valid = 1; bus.issue_wave = 4; bus.issue_type = 2;
        bus.ret_valid   = 1; bus.ret_wave   = 4; bus.ret_type   = 2;
        @(posedge clk); #1;
        bus.issue_valid = 0; bus.ret_valid = 0;
        #1;
        repeat (60) issue_op(4, 2);
        check("ovf_ready_at_62", 32'(bus.issue_ready), 1);
        issue_op(4, 2);
        check("ovf_ready_at_63", 32'(bus.issue_ready), 0);
        check("ovf_err_before", 32'(bus.err_overflow), 0);
        issue_op(4, 2);
        check("ovf_err_after", 32'(bus.err_overflow), 32'(ERR_EN));
        check("ovf_still_full", 32'(bus.issue_ready), 0);
        ret_op(4, 2);
        check("ovf_ready_after_ret", 32'(bus.issue_ready), 1);
        check("ovf_err_sticky", 32'(bus.err_overflow), 32'(ERR_EN));

        // wave 6 vs return at zero
        check("unf_err_before", 32'(bus.err_underflow), 0);
        ret_op(6, 0);
        check("unf_err_after", 32'(bus.err_underflow), 32'(ERR_EN));
        wait_req(6, 0, 0);
        cyc();
        check("unf_count_zero_done", 32'(bus.done_valid), 1);
        check("unf_done_wave", 32'(bus.done_wave), 6);
        cyc();

        // wave 7 waiting on vm=5, reset mid-cycle
        repeat (5) issue_op(7, 1);
        wait_req(7, 1, 0);
        check("rstmid_stall_set", 32'(bus.wave_stall[7]), 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_stall", 32'(bus.wave_stall), 0);
        check("rstmid_done", 32'(bus.done_valid), 0);
        check("rstmid_wait_ready", 32'(bus.wait_ready), 1);
        check("rstmid_err_ovf", 32'(bus.err_overflow), 0);
        check("rstmid_err_unf", 32'(bus.err_underflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        cyc();
        check("rstmid_no_done_later", 32'(bus.done_valid), 0);
        bus.issue_wave = 4; bus.issue_type = 2;
        #1;
        check("rstmid_w4_ready", 32'(bus.issue_ready), 1);
        wait_req(7, 1, 0);
        cyc();
        check("rstmid_cnt_zero_done", 32'(bus.done_valid), 1);
        check("rstmid_done_wave", 32'(bus.done_wave), 7);
        cyc();
        check("rstmid_final_stall", 32'(bus.wave_stall), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
